// File: rtl/seq_dmem_pkg.sv
// Shared encodings and helpers for the sequential core's data-memory responder.
package seq_dmem_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Bytes touched by an access of the given size starting at the given lane.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            SZ_D:    base = 8'hFF;
            default: base = 8'h00;
        endcase
        return 8'(base << offset);
    endfunction

    // Offset bits that survive natural alignment for the given size.
    function automatic logic [2:0] align_keep(input logic [1:0] size);
        logic [2:0] keep;
        case (size)
            SZ_B:    keep = 3'b111;
            SZ_H:    keep = 3'b110;
            SZ_W:    keep = 3'b100;
            SZ_D:    keep = 3'b000;
            default: keep = 3'b000;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/seq_dmem_lane.sv
// Byte-lane steering: load extraction with sign/zero extension and store merge.
module seq_dmem_lane
    import seq_dmem_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_word
);

    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] wshift_s;
    logic [7:0]      mask_s;

    // Load path: bring the addressed lane to bit 0, then extend.
    always_comb begin
        shifted_s = word >> {offset, 3'b000};
        case (size)
            SZ_B: load_data = is_unsigned ? {56'd0, shifted_s[7:0]}
                                          : {{56{shifted_s[7]}}, shifted_s[7:0]};
            SZ_H: load_data = is_unsigned ? {48'd0, shifted_s[15:0]}
                                          : {{48{shifted_s[15]}}, shifted_s[15:0]};
            SZ_W: load_data = is_unsigned ? {32'd0, shifted_s[31:0]}
                                          : {{32{shifted_s[31]}}, shifted_s[31:0]};
            SZ_D:    load_data = shifted_s;
            default: load_data = shifted_s;
        endcase
    end

    // Store path: replace only the masked bytes of the old word.
    always_comb begin
        wshift_s   = wdata << {offset, 3'b000};
        mask_s     = byte_mask(size, offset);
        store_word = word;
        for (int i = 0; i < 8; i++) begin
            if (mask_s[i]) begin
                store_word[8*i +: 8] = wshift_s[8*i +: 8];
            end else begin
                store_word[8*i +: 8] = word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/seq_dmem_responder.sv
// Data-memory responder with programmable wait states and a valid/ready response.
// Optional build macro SEQ_DMEM_ALIGN_CHECK_EN turns misaligned accesses into faults.
module seq_dmem_responder #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);
    import seq_dmem_pkg::*;

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         WIDX_W   = ADDR_W - 3;
    localparam logic [3:0] LAT_LOAD = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_e            state_r, state_nxt_s;
    logic [3:0]        cnt_r;
    logic              we_r, uns_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        size_r;
    logic [XLEN-1:0]   wdata_r;
    logic              rsp_valid_r, rsp_err_r;
    logic [XLEN-1:0]   rsp_rdata_r;
    logic [XLEN-1:0]   mem_r [DEPTH];

    logic              accept_s, commit_s, err_s, misalign_s, range_err_s;
    logic              cur_we_s, cur_uns_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [1:0]        cur_size_s;
    logic [XLEN-1:0]   cur_wdata_s, load_data_s, store_word_s;
    logic [2:0]        eff_off_s;
    logic [IDX_W-1:0]  widx_s;

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign accept_s  = (state_r == ST_IDLE) && req_valid;
    assign commit_s  = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // With zero latency the commit happens on the accepting edge, so use the live request.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_we_s    = req_we;
            cur_addr_s  = req_addr;
            cur_size_s  = req_size;
            cur_uns_s   = req_unsigned;
            cur_wdata_s = req_wdata;
        end else begin
            cur_we_s    = we_r;
            cur_addr_s  = addr_r;
            cur_size_s  = size_r;
            cur_uns_s   = uns_r;
            cur_wdata_s = wdata_r;
        end
    end

    // Range and alignment decode of the access being committed.
    always_comb begin
        range_err_s = (cur_addr_s[ADDR_W-1:3] >= WIDX_W'(DEPTH));
        widx_s      = cur_addr_s[3 +: IDX_W];
`ifdef SEQ_DMEM_ALIGN_CHECK_EN
        eff_off_s   = cur_addr_s[2:0];
        misalign_s  = |(cur_addr_s[2:0] & ~align_keep(cur_size_s));
`else
        eff_off_s   = cur_addr_s[2:0] & align_keep(cur_size_s);
        misalign_s  = 1'b0;
`endif
        err_s       = range_err_s || misalign_s;
    end

    seq_dmem_lane u_lane (
        .word        (mem_r[widx_s]),
        .offset      (eff_off_s),
        .size        (cur_size_s),
        .is_unsigned (cur_uns_s),
        .wdata       (cur_wdata_s),
        .load_data   (load_data_s),
        .store_word  (store_word_s)
    );

    // Request latch and wait-state counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            wdata_r <= '0;
        end else if (accept_s) begin
            cnt_r   <= LAT_LOAD;
            we_r    <= req_we;
            addr_r  <= req_addr;
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            wdata_r <= req_wdata;
        end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response registers: captured on the commit edge, held until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else if (commit_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || cur_we_s) ? '0 : load_data_s;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end
    end

    // Memory array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && commit_s && cur_we_s && !err_s) begin
            mem_r[widx_s] <= store_word_s;
        end
    end

endmodule

// File: tb/tb_seq_dmem_responder.sv
// Directed self-checking bench for seq_dmem_responder (DEPTH 256, LATENCY 2).
module tb_seq_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] rd;
    logic        er;
    int          lat;
    logic        seen;

    seq_dmem_responder #(.XLEN(64), .DEPTH(256), .ADDR_W(32), .LATENCY(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction; lat counts edges from the accepting edge to rsp_valid visible.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata, input int hold,
                       output logic [63:0] rdata, output logic err, output int latency);
        logic [63:0] held;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        latency = 1;
        while (!rsp_valid && latency < 20) begin
            @(posedge clk);
            #1 latency++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        held  = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold rsp_rdata", rsp_rdata, held);
            check("hold req_ready", {63'd0, req_ready}, 64'd0);
        end
        if (rsp_valid) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            check("rsp_valid after handshake", {63'd0, rsp_valid}, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 64'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset req_ready", {63'd0, req_ready}, 64'd1);
        check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset rsp_err", {63'd0, rsp_err}, 64'd0);
        check("reset rsp_rdata", rsp_rdata, 64'd0);

        txn(1'b1, 32'h10, 2'b11, 1'b0, 64'h8877665544332211, 0, rd, er, lat);
        check("store latency", 64'(lat), 64'd3);
        check("store err", {63'd0, er}, 64'd0);
        check("store rdata", rd, 64'd0);

        txn(1'b0, 32'h10, 2'b11, 1'b0, 64'd0, 0, rd, er, lat);
        check("load D 0x10", rd, 64'h8877665544332211);
        check("load latency", 64'(lat), 64'd3);

        txn(1'b0, 32'h17, 2'b00, 1'b0, 64'd0, 0, rd, er, lat);
        check("load B 0x17 signed", rd, 64'hFFFFFFFFFFFFFF88);
        txn(1'b0, 32'h17, 2'b00, 1'b1, 64'd0, 0, rd, er, lat);
        check("load BU 0x17", rd, 64'h0000000000000088);

        txn(1'b1, 32'h12, 2'b01, 1'b0, 64'h000000000000BEEF, 0, rd, er, lat);
        check("store H err", {63'd0, er}, 64'd0);
        txn(1'b0, 32'h10, 2'b11, 1'b0, 64'd0, 0, rd, er, lat);
        check("half merge", rd, 64'h88776655BEEF2211);

        txn(1'b0, 32'h800, 2'b11, 1'b0, 64'd0, 0, rd, er, lat);
        check("oor err", {63'd0, er}, 64'd1);
        check("oor rdata", rd, 64'd0);

        txn(1'b0, 32'h10, 2'b11, 1'b0, 64'd0, 5, rd, er, lat);
        check("backpressure data", rd, 64'h88776655BEEF2211);

        txn(1'b0, 32'h12, 2'b10, 1'b0, 64'd0, 0, rd, er, lat);
`ifdef SEQ_DMEM_ALIGN_CHECK_EN
        check("misaligned W err", {63'd0, er}, 64'd1);
        check("misaligned W rdata", rd, 64'd0);
`else
        check("misaligned W err", {63'd0, er}, 64'd0);
        check("misaligned W rdata", rd, 64'hFFFFFFFFBEEF2211);
`endif

        txn(1'b1, 32'h20, 2'b11, 1'b0, 64'h0123456789ABCDEF, 0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'b11;
        req_unsigned = 1'b0; req_wdata = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst mid-wait req_ready", {63'd0, req_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 if (rsp_valid) seen = 1'b1;
        end
        check("rst mid-wait no rsp", {63'd0, seen}, 64'd0);
        txn(1'b0, 32'h20, 2'b11, 1'b0, 64'd0, 0, rd, er, lat);
        check("rst dropped store", rd, 64'h0123456789ABCDEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
